player_anim_ctrl: RTL and testbench
===================================

Name: player_anim_ctrl

Overview:
- Upstream neighbour of the player sprite addressing stage.
- Runs once per frame_Clk tick. Tracks the player's animation state (idle / run / jump) and a frame-hold counter.
- Produces the animationOffset word that the sprite addressing stage adds to its per-pixel address and direction offset.
- Output is a registered word offset into one direction-half of the player sprite sheet.

Parameters:
FRAME_WORDS, 1080, words per sprite frame (24 x 45)
IDLE_BASE, 0, sheet frame index of the idle frame
RUN_BASE, 1, first run frame index
RUN_FRAMES, 6, number of run frames
JUMP_BASE, 7, first jump (spin) frame index
JUMP_FRAMES, 4, number of jump frames
RUN_HOLD, 6, frame_Clk ticks each run frame is shown
JUMP_HOLD, 4, frame_Clk ticks each jump frame is shown

Ports:
frame_Clk  in  1  frame-rate clock (one edge per video frame)
Reset_n  in  1  asynchronous active-low reset
freeze  in  1  pause: hold all state and outputs
moving  in  1  left/right input held
onGround  in  1  player feet on a platform
shoot  in  1  fire button held (used only with the optional feature)
animationOffset  out  32  (sheet frame index) x FRAME_WORDS, registered
animState  out  2  00 IDLE, 01 RUN, 10 JUMP, 11 reserved/SHOOT
frameIdx  out  3  current index within the active animation

Behaviour:
- Reset (Reset_n low, async): state IDLE, frameIdx 0, hold counter 0, animationOffset = IDLE_BASE*FRAME_WORDS = 0.
- Release of reset is synchronised by the codebase reset bridge. Reset asserted mid-animation clears everything immediately, without waiting for a clock edge.
- Next-state priority is evaluated every tick with freeze low:
  - !onGround -> JUMP
  - else moving -> RUN
  - else IDLE
- State change:
  - frameIdx <= 0 and hold counter <= 0 on the same edge.
  - animationOffset <= new_base*FRAME_WORDS on that edge.
- Same state, RUN:
  - Hold counter counts 0..RUN_HOLD-1.
  - When the counter is at RUN_HOLD-1: counter wraps to 0 and frameIdx advances mod RUN_FRAMES (5 -> 0).
- Same state, JUMP: same as RUN, using JUMP_HOLD and JUMP_FRAMES. The jump animation loops (spin) and does not saturate.
- IDLE: frameIdx stays 0; hold counter stays 0.
- animationOffset = (base + frameIdx)*FRAME_WORDS.
  - Computed from next-state values and registered, so it always matches animState/frameIdx on the same cycle.
  - Latency is one frame_Clk from an input change to the offset change.
- freeze high:
  - No register changes, including the hold counter.
  - freeze has priority over state changes. Inputs that change while frozen are evaluated on the first unfrozen tick.
- Landing (onGround rises while in JUMP):
  - Goes to RUN if moving, else IDLE, at frameIdx 0.
  - Any partial hold count is discarded.
- Arithmetic:
  - Multiply in 32 bits unsigned; no overflow at the defaults (max 10*1080).
  - frameIdx is 3 bits; RUN_FRAMES and JUMP_FRAMES are at most 8.
  - Hold counter is 4 bits; RUN_HOLD and JUMP_HOLD are at most 16.
- The direction offset is not handled here. It is added downstream.

Optional Feature:
- Macro PLAYER_ANIM_SHOOT_EN.
- Defined:
  - Adds state SHOOT (animState 11), entered when onGround && !moving && shoot. Priority order: JUMP > RUN > SHOOT > IDLE.
  - SHOOT shows a single frame at sheet index 11 (offset 11880) for as long as shoot stays high.
  - On exit, normal priority rules apply, with frameIdx reset to 0.
- Undefined:
  - The shoot port exists but is ignored.
  - animState never reports 11.

Test Plan:
- Reset_n low mid-run with frameIdx=3 -> all outputs 0 and animState=00 immediately, with no clock edge needed.
- onGround=1, moving=1 from IDLE -> next tick: animState=01, offset=1080. After 6 more ticks: offset=2160. After 36 ticks total: wraps back to 1080.
- onGround=0 during RUN frameIdx=4 -> next tick: animState=10, offset=7560. Every 4 ticks the offset steps by 1080 up to 10800, then wraps to 7560.
- Landing with moving=0 at jump frameIdx=2 -> next tick: animState=00, offset=0.
- freeze=1 for 10 ticks during RUN at frameIdx=2, hold count 3 -> outputs unchanged. After release, 3 more ticks advance to frameIdx=3 (offset 4320).
- With PLAYER_ANIM_SHOOT_EN: onGround=1, moving=0, shoot=1 -> animState=11, offset=11880. Raising moving gives RUN, offset=1080.

Source files
------------

// File: rtl/player_anim_ctrl_if.sv
// player_anim_ctrl_if: control inputs and animation outputs of the player animation controller.
interface player_anim_ctrl_if;
    logic        freeze;
    logic        moving;
    logic        onGround;
    logic        shoot;
    logic [31:0] animationOffset;
    logic [1:0]  animState;
    logic [2:0]  frameIdx;

    modport master (
        output freeze, moving, onGround, shoot,
        input  animationOffset, animState, frameIdx
    );
    modport slave (
        input  freeze, moving, onGround, shoot,
        output animationOffset, animState, frameIdx
    );
endinterface

// File: rtl/player_anim_ctrl.sv
// player_anim_ctrl: per-frame idle/run/jump animation state and registered sprite-sheet word offset.
// Optional SHOOT state enabled by defining PLAYER_ANIM_SHOOT_EN.
module player_anim_ctrl #(
    parameter int unsigned FRAME_WORDS = 1080,
    parameter int unsigned IDLE_BASE   = 0,
    parameter int unsigned RUN_BASE    = 1,
    parameter int unsigned RUN_FRAMES  = 6,
    parameter int unsigned JUMP_BASE   = 7,
    parameter int unsigned JUMP_FRAMES = 4,
    parameter int unsigned RUN_HOLD    = 6,
    parameter int unsigned JUMP_HOLD   = 4,
    parameter int unsigned SHOOT_BASE  = 11
) (
    input  logic                      frame_Clk,
    input  logic                      Reset_n,
    player_anim_ctrl_if.slave         bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, JUMP = 2'b10, SHOOT = 2'b11} state_e;

    state_e      state_q, state_d, tgt;
    logic [2:0]  idx_q, idx_d, idx_last;
    logic [3:0]  hold_q, hold_d, hold_last;
    logic [31:0] off_q, off_d, base;
    logic        anim, restart, wrap;

`ifdef PLAYER_ANIM_SHOOT_EN
    assign tgt = !bus.onGround ? JUMP : bus.moving ? RUN : bus.shoot ? SHOOT : IDLE;
`else
    logic unused_shoot;
    assign unused_shoot = bus.shoot;
    assign tgt = !bus.onGround ? JUMP : bus.moving ? RUN : IDLE;
`endif

    assign base      = tgt == JUMP ? JUMP_BASE : tgt == RUN ? RUN_BASE : tgt == SHOOT ? SHOOT_BASE : IDLE_BASE;
    assign hold_last = 4'(tgt == JUMP ? JUMP_HOLD - 1 : RUN_HOLD - 1);
    assign idx_last  = 3'(tgt == JUMP ? JUMP_FRAMES - 1 : RUN_FRAMES - 1);
    assign anim      = tgt == RUN || tgt == JUMP;
    // Entering a new state or sitting in a single-frame state keeps index and hold at zero.
    assign restart   = tgt != state_q || !anim;
    assign wrap      = hold_q == hold_last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        off_d   = off_q;
        if (!bus.freeze) begin
            state_d = tgt;
            idx_d   = restart ? 3'd0 : wrap ? (idx_q == idx_last ? 3'd0 : idx_q + 3'd1) : idx_q;
            hold_d  = restart || wrap ? 4'd0 : hold_q + 4'd1;
            off_d   = (base + 32'(idx_d)) * FRAME_WORDS;
        end
    end

    always_ff @(posedge frame_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            off_q   <= IDLE_BASE * FRAME_WORDS;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            off_q   <= off_d;
        end
    end

    assign bus.animationOffset = off_q;
    assign bus.animState       = state_q;
    assign bus.frameIdx        = idx_q;
endmodule

// File: tb/tb_player_anim_ctrl.sv
// tb_player_anim_ctrl: directed checks of player_anim_ctrl against hand-computed offsets.
module tb_player_anim_ctrl;
    logic frame_Clk = 1'b0;
    logic Reset_n   = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    player_anim_ctrl_if bus ();

    player_anim_ctrl dut (
        .frame_Clk (frame_Clk),
        .Reset_n   (Reset_n),
        .bus       (bus.slave)
    );

    always #5 frame_Clk = ~frame_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge frame_Clk);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [2:0] idx, input logic [31:0] off);
        check({tag, ".state"}, 32'(bus.animState), 32'(st));
        check({tag, ".idx"}, 32'(bus.frameIdx), 32'(idx));
        check({tag, ".off"}, bus.animationOffset, off);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.freeze = 1'b0; bus.moving = 1'b0; bus.onGround = 1'b1; bus.shoot = 1'b0;
        tick(2);
        expect_out("reset", 2'b00, 3'd0, 32'd0);
        Reset_n = 1'b1;
        tick(2);
        expect_out("idle", 2'b00, 3'd0, 32'd0);

`ifndef PLAYER_ANIM_SHOOT_EN
        bus.shoot = 1'b1;
        tick(1);
        expect_out("shoot_ignored", 2'b00, 3'd0, 32'd0);
        bus.shoot = 1'b0;
`endif

        // Run: one frame per 6 ticks, six frames, then wrap.
        bus.moving = 1'b1;
        tick(1);  expect_out("run_enter", 2'b01, 3'd0, 32'd1080);
        tick(5);  expect_out("run_hold", 2'b01, 3'd0, 32'd1080);
        tick(1);  expect_out("run_f1", 2'b01, 3'd1, 32'd2160);
        tick(24); expect_out("run_f5", 2'b01, 3'd5, 32'd6480);
        tick(6);  expect_out("run_wrap", 2'b01, 3'd0, 32'd1080);
        tick(24); expect_out("run_f4", 2'b01, 3'd4, 32'd5400);

        // Jump: spin through four frames every 4 ticks and loop.
        bus.onGround = 1'b0;
        tick(1);  expect_out("jump_enter", 2'b10, 3'd0, 32'd7560);
        tick(4);  expect_out("jump_f1", 2'b10, 3'd1, 32'd8640);
        tick(8);  expect_out("jump_f3", 2'b10, 3'd3, 32'd10800);
        tick(4);  expect_out("jump_wrap", 2'b10, 3'd0, 32'd7560);
        tick(10); expect_out("jump_f2", 2'b10, 3'd2, 32'd9720);
        bus.moving = 1'b0; bus.onGround = 1'b1;
        tick(1);  expect_out("land_idle", 2'b00, 3'd0, 32'd0);

        // Run to frame 2 with hold count 3, then freeze.
        bus.moving = 1'b1;
        tick(1);  expect_out("run2_enter", 2'b01, 3'd0, 32'd1080);
        tick(15); expect_out("run2_f2", 2'b01, 3'd2, 32'd3240);
        bus.freeze = 1'b1;
        tick(4);  expect_out("frozen_a", 2'b01, 3'd2, 32'd3240);
        bus.moving = 1'b0; bus.onGround = 1'b0;
        tick(3);  expect_out("frozen_b", 2'b01, 3'd2, 32'd3240);
        bus.moving = 1'b1; bus.onGround = 1'b1;
        tick(3);  expect_out("frozen_c", 2'b01, 3'd2, 32'd3240);
        bus.freeze = 1'b0;
        tick(2);  expect_out("thaw_hold", 2'b01, 3'd2, 32'd3240);
        tick(1);  expect_out("thaw_f3", 2'b01, 3'd3, 32'd4320);

        // Asynchronous reset takes effect away from any clock edge.
        #1 Reset_n = 1'b0;
        #1 expect_out("async_reset", 2'b00, 3'd0, 32'd0);
        tick(1);
        Reset_n = 1'b1;
        tick(1);  expect_out("post_reset_run", 2'b01, 3'd0, 32'd1080);

`ifdef PLAYER_ANIM_SHOOT_EN
        bus.moving = 1'b0; bus.shoot = 1'b1;
        tick(1);  expect_out("shoot", 2'b11, 3'd0, 32'd11880);
        tick(3);  expect_out("shoot_hold", 2'b11, 3'd0, 32'd11880);
        bus.moving = 1'b1;
        tick(1);  expect_out("shoot_run", 2'b01, 3'd0, 32'd1080);
        bus.moving = 1'b0; bus.shoot = 1'b0;
        tick(1);  expect_out("shoot_idle", 2'b00, 3'd0, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
